// File: rtl/riscv_div_pkg.sv
// rtl/riscv_div_pkg.sv - shared types and constants for the RV32M divider
package riscv_div_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } div_state_t;

   localparam logic [31:0] DIV_MIN_NEG = 32'h8000_0000;

   // funct3[0] clear selects the signed variants (DIV, REM)
   function automatic logic op_is_signed(input div_op_t op);
      return !op[0];
   endfunction

endpackage

// File: rtl/riscv_div_unit_step.sv
// rtl/riscv_div_unit_step.sv - one combinational restoring-division iteration
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic            dividend_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // rem_in < divisor, so a borrow always shows up in the top bit
   always_comb begin
      shifted = {rem_in, dividend_bit};
      trial   = shifted - {1'b0, divisor};
      q_bit   = !trial[XLEN];
      rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/riscv_div_unit.sv
// rtl/riscv_div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
module riscv_div_unit
   import riscv_div_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   input  logic            kill,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam logic [XLEN-1:0] MIN_NEG = XLEN'(DIV_MIN_NEG);

   div_state_t       state_q, state_d;
   div_op_t          op_q, op_d;
   logic [4:0]       rd_q, rd_d;
   logic [XLEN-1:0]  dvd_q, dvd_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             last_q, last_d;

   div_op_t         op_in;
   logic            signed_in;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN-1:0] step_rem;
   logic            step_q;
   logic [XLEN-1:0] q_fix, r_fix;

   assign op_in     = div_op_t'(op);
   assign signed_in = op_is_signed(op_in);
   assign abs_a     = (signed_in && a[XLEN-1]) ? -a : a;
   assign abs_b     = (signed_in && b[XLEN-1]) ? -b : b;
   assign q_fix     = (q_neg_q && op_is_signed(op_q)) ? -dvd_q : dvd_q;
   assign r_fix     = (r_neg_q && op_is_signed(op_q)) ? -rem_q : rem_q;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_in       (rem_q),
      .dividend_bit (dvd_q[XLEN-1]),
      .divisor      (dvs_q),
      .rem_out      (step_rem),
      .q_bit        (step_q)
   );

   // dvd_q shifts the dividend out at the top and the quotient in at the bottom
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      last_d   = last_q;
      case (state_q)
         IDLE: begin
            if (start && !kill) begin
               op_d    = op_in;
               rd_d    = rd_in;
               dvd_d   = abs_a;
               dvs_d   = abs_b;
               rem_d   = '0;
               q_neg_d = a[XLEN-1] ^ b[XLEN-1];
               r_neg_d = a[XLEN-1];
               cnt_d   = CNT_W'(XLEN - 1);
               last_d  = 1'b0;
               if (b == '0) begin
                  result_d = op[1] ? a : '1;
                  state_d  = FINISH;
               end else if (signed_in && a == MIN_NEG && b == '1) begin
                  result_d = op[1] ? '0 : MIN_NEG;
                  state_d  = FINISH;
               end else begin
                  state_d  = CALC;
               end
            end
         end
         CALC: begin
            if (kill) begin
               state_d = IDLE;
            end else if (last_q) begin
               result_d = op_q[1] ? r_fix : q_fix;
               last_d   = 1'b0;
               state_d  = FINISH;
            end else begin
               rem_d = step_rem;
               dvd_d = {dvd_q[XLEN-2:0], step_q};
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  last_d = 1'b1;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= DIV;
         rd_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         last_q   <= last_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FINISH) && !kill;
   assign result = result_q;
   assign rd_out = rd_q;

endmodule
